button_events: RTL

// - Consumes the debounced button levels produced by the debounce stage, one per button.
// - Turns level changes into a stream of discrete events: press, release and optional auto-repeat.
// - Events leave through a single valid/ready port to the joypad/host logic.
// - Per-button pending slots and a round-robin arbiter serialize simultaneous changes.

---
 rtl/button_events.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/button_events.sv
// Turns debounced button levels into press/release/repeat events on one valid/ready port.
// Auto-repeat (prescaler + per-button hold counters) is built only when BUTTON_EVENTS_REPEAT_EN is defined.
module button_events #(
  parameter int WIDTH        = 8,
  parameter int PRESCALE     = 1000,
  parameter int HOLD_TICKS   = 50,
  parameter int REPEAT_TICKS = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         btn,
  output logic [WIDTH-1:0]         pressed,
  output logic                     ev_valid,
  input  logic                     ev_ready,
  output logic [1:0]               ev_kind,
  output logic [$clog2(WIDTH)-1:0] ev_idx,
  output logic                     overflow
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [1:0] K_NONE    = 2'b00;
  localparam logic [1:0] K_PRESS   = 2'b01;
  localparam logic [1:0] K_RELEASE = 2'b10;
  localparam logic [1:0] K_REPEAT  = 2'b11;

  if (WIDTH < 2 || PRESCALE < 2 || HOLD_TICKS < 1 || REPEAT_TICKS < 1) begin : g_param_check
    $error("button_events: parameter out of range");
  end

  // Handshake: an event transfers on a posedge where ev_valid && ev_ready; while
  // ev_valid && !ev_ready the outputs hold, and the register reloads whenever it is free.
  logic [1:0]       slot [WIDTH];
  logic [1:0]       new_kind [WIDTH];
  logic [WIDTH-1:0] press_edge;
  logic [WIDTH-1:0] release_edge;
  logic [WIDTH-1:0] repeat_post;
  logic [WIDTH-1:0] consume;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    sel;
  logic [IW-1:0]    ptr_next;
  logic             found;
  logic             load;

  assign press_edge   = btn & ~pressed;
  assign release_edge = ~btn & pressed;
  assign load         = !ev_valid || ev_ready;
  assign ptr_next     = (sel == IW'(WIDTH - 1)) ? '0 : sel + 1'b1;

`ifdef BUTTON_EVENTS_REPEAT_EN
  localparam int MAXT = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
  localparam int CW   = $clog2(MAXT + 1);
  localparam int PW   = $clog2(PRESCALE);

  logic [PW-1:0] pcnt;
  logic          tick;
  logic [CW-1:0] cnt [WIDTH];

  assign tick = (pcnt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt <= '0;
    end else if (tick) begin
      pcnt <= PW'(PRESCALE - 1);
    end else begin
      pcnt <= pcnt - 1'b1;
    end
  end

  // A press edge always reloads, even on a tick; a release edge always wins over a repeat.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WIDTH; i++) begin
      if (reset || release_edge[i]) begin
        cnt[i] <= '0;
      end else if (press_edge[i]) begin
        cnt[i] <= CW'(HOLD_TICKS);
      end else if (btn[i] && pressed[i] && tick) begin
        if (cnt[i] == CW'(1)) begin
          cnt[i] <= CW'(REPEAT_TICKS);
        end else if (cnt[i] != '0) begin
          cnt[i] <= cnt[i] - 1'b1;
        end
      end
    end
  end

  always_comb begin
    repeat_post = '0;
    for (int i = 0; i < WIDTH; i++) begin
      repeat_post[i] = btn[i] && pressed[i] && tick && (cnt[i] == CW'(1));
    end
  end
`else
  assign repeat_post = '0;
`endif

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      if (press_edge[i]) begin
        new_kind[i] = K_PRESS;
      end else if (release_edge[i]) begin
        new_kind[i] = K_RELEASE;
      end else if (repeat_post[i]) begin
        new_kind[i] = K_REPEAT;
      end else begin
        new_kind[i] = K_NONE;
      end
    end
  end

  // Round-robin pick: first occupied slot at or after ptr, wrapping.
  always_comb begin
    int j;
    j     = 0;
    found = 1'b0;
    sel   = ptr;
    for (int i = 0; i < WIDTH; i++) begin
      j = int'(ptr) + i;
      if (j >= WIDTH) j = j - WIDTH;
      if (!found && slot[IW'(j)] != K_NONE) begin
        found = 1'b1;
        sel   = IW'(j);
      end
    end
  end

  always_comb begin
    consume = '0;
    for (int i = 0; i < WIDTH; i++) begin
      consume[i] = load && found && (sel == IW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pressed  <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < WIDTH; i++) slot[i] <= K_NONE;
    end else begin
      pressed <= btn;
      for (int i = 0; i < WIDTH; i++) begin
        if (new_kind[i] != K_NONE) begin
          slot[i] <= new_kind[i];
          if (slot[i] != K_NONE && !consume[i]) overflow <= 1'b1;
        end else if (consume[i]) begin
          slot[i] <= K_NONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ev_valid <= 1'b0;
      ev_kind  <= K_NONE;
      ev_idx   <= '0;
      ptr      <= '0;
    end else if (load) begin
      if (found) begin
        ev_valid <= 1'b1;
        ev_kind  <= slot[sel];
        ev_idx   <= sel;
        ptr      <= ptr_next;
      end else begin
        ev_valid <= 1'b0;
      end
    end
  end

endmodule
